// File: rtl/wash_entry_pkg.sv
// Shared definitions for the wash-entry panel: one-hot session phases and
// the BCD digit limit used by the balance counters.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY = 3'b001,
    ST_MODE  = 3'b010,
    ST_READY = 3'b100
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/wash_entry_if.sv
// Panel-side signal bundle of the wash-entry block: switches and raw buttons
// in, balance/mode/phase and event pulses out.
interface wash_entry_if #(
  parameter int DIGITS = 3,
  parameter int MODES  = 4
);
  localparam int MODE_W = $clog2(MODES);

  logic [DIGITS-1:0]   dig_sw;
  logic                sign_sw;
  logic                mode_bt;
  logic                ok_bt;
  logic [4*DIGITS-1:0] digits;
  logic                neg;
  logic [MODE_W-1:0]   mode;
  logic [2:0]          state;
  logic                start;
  logic                err;

  modport master (
    output dig_sw, sign_sw, mode_bt, ok_bt,
    input  digits, neg, mode, state, start, err
  );

  modport slave (
    input  dig_sw, sign_sw, mode_bt, ok_bt,
    output digits, neg, mode, state, start, err
  );

endinterface

// File: rtl/wash_entry_btn_edge.sv
// Button conditioner: two-flop synchroniser followed by a rising-edge
// detector, giving one single-cycle pulse per press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/wash_entry.sv
// Wash-panel session controller: BCD balance entry, wash-mode selection and
// confirmation, driven by two conditioned buttons and a periodic tick.
module wash_entry
  import wash_pkg::*;
#(
  parameter int DIGITS        = 3,
  parameter int TICK_CYC      = 66000000,
  parameter int MODES         = 4,
  parameter int TIMEOUT_TICKS = 15
) (
  input logic         clk,
  input logic         rst,
  wash_entry_if.slave bus
);

  localparam int MODE_W = $clog2(MODES);
  localparam int TICK_W = $clog2(TICK_CYC);
  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);

  state_t              state_q;
  state_t              state_d;
  logic [TICK_W-1:0]   tick_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [4*DIGITS-1:0] digits_q;
  logic [4*DIGITS-1:0] digits_d;
  logic                neg_q;
  logic                neg_d;
  logic [MODE_W-1:0]   mode_q;
  logic [MODE_W-1:0]   mode_d;
  logic                start_q;
  logic                start_d;
  logic                err_q;
  logic                err_d;
  logic                tick;
  logic                mode_p;
  logic                ok_p;
  logic                entry_ok;
  logic                timeout;
  logic                leave_entry;

  btn_edge u_mode_btn (.clk(clk), .rst(rst), .raw(bus.mode_bt), .pulse(mode_p));
  btn_edge u_ok_btn   (.clk(clk), .rst(rst), .raw(bus.ok_bt),   .pulse(ok_p));

  assign tick        = (tick_cnt == TICK_W'(TICK_CYC - 1));
  assign entry_ok    = (bus.dig_sw == '0) && !bus.sign_sw && !neg_q;
  assign leave_entry = (state_q == ST_ENTRY) && (state_d == ST_MODE);
  // A button pulse in the same cycle as the final idle tick keeps the session alive.
  assign timeout     = (state_q == ST_MODE) && tick && !mode_p && !ok_p &&
                       (idle_cnt == IDLE_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (leave_entry || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (state_q != ST_MODE || mode_p || ok_p) begin
      idle_cnt <= '0;
    end else if (tick) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ENTRY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTRY: if (ok_p && entry_ok) state_d = ST_MODE;
      ST_MODE: begin
        if (ok_p)         state_d = ST_READY;
        else if (timeout) state_d = ST_ENTRY;
      end
      ST_READY: if (ok_p) state_d = ST_ENTRY;
      default:  state_d = ST_ENTRY;
    endcase
  end

  // The ok action always wins over a coincident tick or mode press.
  always_comb begin
    digits_d = digits_q;
    neg_d    = neg_q;
    mode_d   = mode_q;
    start_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (ok_p) begin
          if (!entry_ok) begin
            digits_d = '0;
            neg_d    = 1'b0;
            err_d    = 1'b1;
          end
        end else if (tick) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (bus.dig_sw[i]) digits_d[4*i +: 4] = bcd_inc(digits_q[4*i +: 4]);
          end
          if (bus.sign_sw) neg_d = ~neg_q;
        end
      end
      ST_MODE: begin
        if (ok_p) begin
          start_d = 1'b1;
        end else if (timeout) begin
          digits_d = '0;
          neg_d    = 1'b0;
          mode_d   = '0;
        end else if (mode_p) begin
          mode_d = (mode_q == MODE_W'(MODES - 1)) ? '0 : mode_q + 1'b1;
        end
      end
      ST_READY: begin
        if (ok_p) begin
          digits_d = '0;
          neg_d    = 1'b0;
          mode_d   = '0;
        end
      end
      default: begin
        digits_d = '0;
        neg_d    = 1'b0;
        mode_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q <= '0;
      neg_q    <= 1'b0;
      mode_q   <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      neg_q    <= neg_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.neg    = neg_q;
  assign bus.mode   = mode_q;
  assign bus.state  = state_q;
  assign bus.start  = start_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_wash_entry.sv
// Bench for wash_entry: directed session scenarios and a random soak, each
// cycle compared against a phase-level model of the panel's behaviour.
module tb_wash_entry;

  localparam int DIGITS        = 3;
  localparam int TICK_CYC      = 4;
  localparam int MODES         = 4;
  localparam int TIMEOUT_TICKS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wash_entry_if #(.DIGITS(DIGITS), .MODES(MODES)) bus ();

  wash_entry #(
    .DIGITS(DIGITS), .TICK_CYC(TICK_CYC), .MODES(MODES), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int start_seen  = 0;
  int err_seen    = 0;

  // Model: phase 0 = entry, 1 = mode select, 2 = ready.
  int       phase;
  int       bal [DIGITS];
  bit       m_neg;
  int       m_mode;
  int       m_cyc;
  int       m_idle;
  int       m_ticks = 0;
  bit       m_start;
  bit       m_err;
  bit [3:0] ok_hist;
  bit [3:0] mode_hist;

  task automatic model_clear();
    for (int i = 0; i < DIGITS; i++) bal[i] = 0;
    m_neg  = 1'b0;
    m_mode = 0;
  endtask

  task automatic model_reset();
    model_clear();
    phase     = 0;
    m_cyc     = 0;
    m_idle    = 0;
    m_start   = 1'b0;
    m_err     = 1'b0;
    ok_hist   = '0;
    mode_hist = '0;
  endtask

  // A press is acted on at the third edge after the raw level rises.
  task automatic model_edge();
    bit tick, okp, mp;
    ok_hist   = {ok_hist[2:0], bus.ok_bt};
    mode_hist = {mode_hist[2:0], bus.mode_bt};
    okp  = ok_hist[2] && !ok_hist[3];
    mp   = mode_hist[2] && !mode_hist[3];
    tick = (m_cyc % TICK_CYC) == TICK_CYC - 1;
    if (tick) m_ticks++;
    m_cyc++;
    m_start = 1'b0;
    m_err   = 1'b0;
    case (phase)
      0: begin
        if (okp) begin
          if (bus.dig_sw == 0 && !bus.sign_sw && !m_neg) begin
            phase  = 1;
            m_idle = 0;
            m_cyc  = 0;
          end else begin
            model_clear();
            m_err = 1'b1;
          end
        end else if (tick) begin
          for (int i = 0; i < DIGITS; i++) if (bus.dig_sw[i]) bal[i] = (bal[i] + 1) % 10;
          if (bus.sign_sw) m_neg = !m_neg;
        end
      end
      1: begin
        if (okp) begin
          phase   = 2;
          m_start = 1'b1;
        end else if (mp) begin
          m_mode = (m_mode + 1) % MODES;
          m_idle = 0;
        end else if (tick) begin
          m_idle++;
          if (m_idle == TIMEOUT_TICKS) begin
            phase = 0;
            model_clear();
          end
        end
      end
      default: begin
        if (okp) begin
          phase = 0;
          model_clear();
        end
      end
    endcase
  endtask

  task automatic compare(string name, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_output(string tag);
    logic [4*DIGITS-1:0] ed;
    for (int i = 0; i < DIGITS; i++) ed[4*i +: 4] = 4'(bal[i]);
    if (bus.start === 1'b1) start_seen++;
    if (bus.err === 1'b1) err_seen++;
    compare($sformatf("%s.digits", tag), 32'(bus.digits), 32'(ed));
    compare($sformatf("%s.neg", tag),    32'(bus.neg),    32'(m_neg));
    compare($sformatf("%s.mode", tag),   32'(bus.mode),   32'(m_mode));
    compare($sformatf("%s.state", tag),  32'(bus.state),  32'(3'b001 << phase));
    compare($sformatf("%s.start", tag),  32'(bus.start),  32'(m_start));
    compare($sformatf("%s.err", tag),    32'(bus.err),    32'(m_err));
  endtask

  task automatic check_reset(string tag);
    compare($sformatf("%s.state", tag),  32'(bus.state),  32'h1);
    compare($sformatf("%s.digits", tag), 32'(bus.digits), 32'h0);
    compare($sformatf("%s.neg", tag),    32'(bus.neg),    32'h0);
    compare($sformatf("%s.mode", tag),   32'(bus.mode),   32'h0);
    compare($sformatf("%s.start", tag),  32'(bus.start),  32'h0);
    compare($sformatf("%s.err", tag),    32'(bus.err),    32'h0);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output(tag);
  endtask

  task automatic apply_stimulus(logic [DIGITS-1:0] dig, logic sign, int n, string tag);
    bus.dig_sw  = dig;
    bus.sign_sw = sign;
    for (int c = 0; c < n; c++) step(tag);
  endtask

  task automatic press(logic m, logic o, string tag);
    bus.mode_bt = m;
    bus.ok_bt   = o;
    for (int c = 0; c < 3; c++) step(tag);
    bus.mode_bt = 1'b0;
    bus.ok_bt   = 1'b0;
    for (int c = 0; c < 3; c++) step(tag);
  endtask

  task automatic run_ticks(int n, string tag);
    int target;
    target = m_ticks + n;
    for (int c = 0; c < TICK_CYC * (n + 1); c++) begin
      if (m_ticks < target) step(tag);
    end
  endtask

  initial begin
    bus.dig_sw  = '0;
    bus.sign_sw = 1'b0;
    bus.mode_bt = 1'b0;
    bus.ok_bt   = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #1 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Units digit wraps 9 -> 0 without carrying into tens.
    apply_stimulus(3'b001, 1'b0, 11 * TICK_CYC, "req35");
    compare("req35.digits_001", 32'(bus.digits), 32'h001);

    // Negative balance is rejected on confirm and the entry is wiped.
    bus.dig_sw  = '0;
    bus.sign_sw = 1'b1;
    run_ticks(1, "req36");
    compare("req36.neg_set", 32'(bus.neg), 32'h1);
    bus.sign_sw = 1'b0;
    press(1'b0, 1'b1, "req36");
    compare("req36.err_count", 32'(err_seen), 32'd1);
    compare("req36.digits", 32'(bus.digits), 32'h0);
    compare("req36.state", 32'(bus.state), 32'h1);

    // Build 250, confirm, cycle modes 5 times, confirm again.
    bus.dig_sw = 3'b110;
    run_ticks(2, "req37");
    bus.dig_sw = 3'b010;
    run_ticks(3, "req37");
    bus.dig_sw = '0;
    compare("req37.digits_250", 32'(bus.digits), 32'h250);
    press(1'b0, 1'b1, "req37");
    compare("req37.state_mode", 32'(bus.state), 32'h2);
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0, "req37");
    compare("req37.mode_1", 32'(bus.mode), 32'h1);
    press(1'b0, 1'b1, "req37");
    compare("req37.state_ready", 32'(bus.state), 32'h4);
    compare("req37.start_count", 32'(start_seen), 32'd1);

    // Idle timeout in mode select, with a press restarting the idle count.
    press(1'b0, 1'b1, "req38");
    press(1'b0, 1'b1, "req38");
    press(1'b1, 1'b0, "req38");
    run_ticks(1, "req38");
    press(1'b1, 1'b0, "req38");
    run_ticks(1, "req38");
    compare("req38.still_mode", 32'(bus.state), 32'h2);
    compare("req38.mode_2", 32'(bus.mode), 32'h2);
    run_ticks(1, "req38");
    compare("req38.timeout_state", 32'(bus.state), 32'h1);
    compare("req38.timeout_mode", 32'(bus.mode), 32'h0);

    // Simultaneous ok and mode: confirm wins, mode untouched.
    press(1'b0, 1'b1, "req39");
    press(1'b1, 1'b0, "req39");
    press(1'b1, 1'b0, "req39");
    press(1'b1, 1'b1, "req39");
    compare("req39.state_ready", 32'(bus.state), 32'h4);
    compare("req39.mode_2", 32'(bus.mode), 32'h2);
    compare("req39.start_count", 32'(start_seen), 32'd2);

    // Reset while ready: immediate clear, no start afterwards.
    step("req40");
    #2 rst = 1'b0;
    #1 check_reset("req40");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus('0, 1'b0, 12, "req40");
    compare("req40.start_count", 32'(start_seen), 32'd2);

    // Confirm held through reset release gives exactly one press.
    #2 rst = 1'b0;
    bus.ok_bt = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus('0, 1'b0, 8, "req31");
    compare("req31.single_press", 32'(bus.state), 32'h2);
    bus.ok_bt = 1'b0;
    apply_stimulus('0, 1'b0, 3, "req31");

    // Random soak against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) bus.ok_bt = ~bus.ok_bt;
      if ($urandom_range(0, 3) == 0) bus.mode_bt = ~bus.mode_bt;
      if ($urandom_range(0, 7) == 0) begin
        bus.dig_sw  = ($urandom_range(0, 2) == 0) ? DIGITS'($urandom) : '0;
        bus.sign_sw = ($urandom_range(0, 5) == 0);
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: bench did not finish, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wash_entry.md
WASH_ENTRY -- requirements
Module: wash_entry

Interface
REQ-001 Parameter DIGITS, default 3: number of BCD balance digits (1..6).
REQ-002 Parameter TICK_CYC, default 66000000: clk cycles per auto-increment tick (>=2).
REQ-003 Parameter MODES, default 4: number of wash modes (2..16).
REQ-004 Parameter TIMEOUT_TICKS, default 15: idle ticks in MODE before abandoning the session (>=1).
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 dig_sw  input  DIGITS  per-digit increment switch, bit 0 = units digit; level-sensitive.
REQ-008 sign_sw  input  1  sign-toggle switch; level-sensitive.
REQ-009 mode_bt  input  1  raw mode-select button, asynchronous to clk.
REQ-010 ok_bt  input  1  raw confirm button, asynchronous to clk.
REQ-011 digits  output  4*DIGITS  BCD balance, digit i in bits [4i+3:4i].
REQ-012 neg  output  1  balance sign, 1 = negative.
REQ-013 mode  output  $clog2(MODES)  selected wash mode.
REQ-014 state  output  3  one-hot phase: 001 ENTRY, 010 MODE, 100 READY.
REQ-015 start  output  1  one-cycle pulse on entry to READY.
REQ-016 err  output  1  one-cycle pulse on a rejected confirm.

Function
REQ-017 Each button SHALL pass through a 2-flop synchroniser plus rising-edge detector; one press = one single-cycle pulse; the FSM SHALL act on the 3rd rising clk edge after the raw input rises.
REQ-018 The tick counter SHALL count 0..TICK_CYC-1 and assert tick for one cycle at TICK_CYC-1, then wrap to 0.
REQ-019 ENTRY: on tick, each digit i with dig_sw[i]=1 SHALL increment, 9 wrapping to 0 with no carry; neg SHALL toggle if sign_sw=1.
REQ-020 ENTRY: digits/neg SHALL hold when no tick or switch is low.
REQ-021 ENTRY + ok pulse: if dig_sw==0, sign_sw==0 and neg==0, go to MODE; otherwise stay in ENTRY, clear digits and neg, pulse err.
REQ-022 ok pulse and tick in the same cycle: ok action only; tick increment discarded.
REQ-023 Leaving ENTRY: tick counter SHALL clear to 0 and restart.
REQ-024 MODE: mode_bt pulse SHALL increment mode, MODES-1 wrapping to 0; digits/neg held.
REQ-025 MODE: ok pulse SHALL go to READY and pulse start in the cycle state first reads 100; if mode_bt pulses in the same cycle, mode is unchanged.
REQ-026 MODE: idle-tick counter SHALL clear on every button pulse and on entry; reaching TIMEOUT_TICKS ticks SHALL return to ENTRY, clearing digits, neg, mode.
REQ-027 READY: mode_bt ignored; ok pulse SHALL return to ENTRY, clearing digits, neg, mode.
REQ-028 state SHALL always be exactly one-hot; an illegal internal encoding SHALL recover to ENTRY on the next edge.

Reset
REQ-029 rst low SHALL immediately force: state=001, digits=0, neg=0, mode=0, start=0, err=0, all counters and synchroniser/edge flops to 0.
REQ-030 Reset mid-session (any state, any counter value) SHALL discard the session; no start/err pulse follows release.
REQ-031 A button held through reset release SHALL produce exactly one pulse after release.

Structure
REQ-032 Shared package wash_pkg SHALL hold the one-hot state constants (ST_ENTRY, ST_MODE, ST_READY) and BCD_MAX=9.
REQ-033 Button conditioning SHALL be a sub-module btn_edge (sync + edge detect), instantiated twice.
REQ-034 Display scanning is out of scope; digits/neg feed the existing scanner externally.

Verification (TICK_CYC=4, DIGITS=3, MODES=4, TIMEOUT_TICKS=3)
REQ-035 Reset, dig_sw=001 for 11 ticks -> digits=0x001 (units 9 wrapped to 0, then 1), no carry into tens.
REQ-036 sign_sw=1 for 1 tick, ok pulse -> err pulse, digits=0, neg=0, state stays 001.
REQ-037 Switches low, digits=0x250, ok -> state=010; 5 mode_bt pulses -> mode=1; ok -> state=100, start high one cycle.
REQ-038 In MODE, no buttons for 3 ticks -> state=001, digits=0, mode=0; a press at tick 2 restarts the count.
REQ-039 ok and mode_bt pulses same cycle in MODE with mode=2 -> state=100, mode=2.
REQ-040 rst asserted in READY mid-tick -> outputs at reset values immediately; no start pulse after release.
